pulse_train_gen: RTL and testbench

Programmable pulse-train generator that sits on the pulse-input side of the pulse-counter board. On a start edge it emits N active-low, debounce-safe pulses of fixed width and period on pulse_out. This drives the counter's count input for self-test and demonstration. It also multiplexes the pulses still to be sent onto the same two-digit seven-segment display format the counter uses.

---
 rtl/pulse_train_if.sv | 23 ++
 rtl/pulse_train_gen.sv | 192 +++++++++++++++++++
 tb/tb_pulse_train_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_if.sv
// Handshake/status bundle between a pulse-train controller and the generator.
// The master side requests trains; the slave side (the generator) reports progress.
interface pulse_train_if;
    logic       start;
    logic       abort;
    logic [7:0] n_pulses;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [7:0] an;
    logic [7:0] seg;

    modport master (
        output start, abort, n_pulses,
        input  pulse_out, busy, done, remaining, an, seg
    );

    modport slave (
        input  start, abort, n_pulses,
        output pulse_out, busy, done, remaining, an, seg
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: on a start edge emits N active-low pulses
// of PULSE_W low cycles and GAP_W high cycles, and shows the count still to be
// sent on a two-digit multiplexed seven-segment display.
module pulse_train_gen #(
    parameter int PULSE_W = 1_000_000,
    parameter int GAP_W   = 9_000_000,
    parameter int REFRESH = 5_000
) (
    input  logic         clk,
    input  logic         rst,
    pulse_train_if.slave bus
);

    localparam logic [31:0] PULSE_LAST   = PULSE_W - 1;
    localparam logic [31:0] GAP_LAST     = GAP_W - 1;
    localparam logic [31:0] REFRESH_LAST = REFRESH - 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [7:0]  rem_q, rem_d;
    logic        pulse_q, pulse_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_q;
    logic [31:0] ref_q, ref_d;
    logic        dsel_q, dsel_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        start_edge;

    // Requests above two displayable digits are clamped to 99.
    function automatic logic [7:0] sat99(input logic [7:0] n);
        return (n > 8'd99) ? 8'd99 : n;
    endfunction

    // Active-low segment pattern (p g f e d c b a) for a decimal digit.
    function automatic logic [7:0] seg_code(input logic [7:0] d);
        logic [7:0] code;
        case (d)
            8'd0:    code = 8'b11000000;
            8'd1:    code = 8'b11111001;
            8'd2:    code = 8'b10100100;
            8'd3:    code = 8'b10110000;
            8'd4:    code = 8'b10011001;
            8'd5:    code = 8'b10010010;
            8'd6:    code = 8'b10000010;
            8'd7:    code = 8'b11111000;
            8'd8:    code = 8'b10000000;
            8'd9:    code = 8'b10010000;
            default: code = 8'b11111111;
        endcase
        return code;
    endfunction

    assign start_edge = bus.start & ~start_q;

    // Train sequencer: next state, phase count, pulse level and status strobes.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                pulse_d = 1'b1;
                busy_d  = 1'b0;
                if (start_edge && !bus.abort) begin
                    if (bus.n_pulses == 8'd0) begin
                        done_d = 1'b1;
                        rem_d  = 8'd0;
                    end else begin
                        rem_d   = sat99(bus.n_pulses);
                        busy_d  = 1'b1;
                        pulse_d = 1'b0;
                        phase_d = 32'd0;
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b1;
                    busy_d  = 1'b0;
                    rem_d   = 8'd0;
                end else if (phase_q == PULSE_LAST) begin
                    pulse_d = 1'b1;
                    rem_d   = rem_q - 8'd1;
                    phase_d = 32'd0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b1;
                    busy_d  = 1'b0;
                    rem_d   = 8'd0;
                end else if (phase_q == GAP_LAST) begin
                    phase_d = 32'd0;
                    if (rem_q != 8'd0) begin
                        pulse_d = 1'b0;
                        state_d = LOW;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b1;
                busy_d  = 1'b0;
                rem_d   = 8'd0;
            end
        endcase
    end

    // Sequencer state and registered train outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= 32'd0;
            rem_q   <= 8'd0;
            pulse_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= bus.start;
        end
    end

    // Display multiplexing: dwell REFRESH cycles per digit, then swap digits.
    always_comb begin
        ref_d  = ref_q + 32'd1;
        dsel_d = dsel_q;
        if (ref_q == REFRESH_LAST) begin
            ref_d  = 32'd0;
            dsel_d = ~dsel_q;
        end
        if (dsel_q) begin
            an_d  = 8'b11111101;
            seg_d = seg_code(rem_q / 8'd10);
        end else begin
            an_d  = 8'b11111110;
            seg_d = seg_code(rem_q % 8'd10);
        end
    end

    // Display registers; they trail the selected digit and count by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_q  <= 32'd0;
            dsel_q <= 1'b0;
            an_q   <= 8'b11111110;
            seg_q  <= 8'b11000000;
        end else begin
            ref_q  <= ref_d;
            dsel_q <= dsel_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: a schedule-based reference model pushes
// the expected outputs for each clock edge as the stimulus is applied, and they
// are popped and compared once the DUT has updated.
module tb_pulse_train_gen;

    localparam int PW  = 3;
    localparam int GW  = 5;
    localparam int RF  = 4;
    localparam int PER = PW + GW;

    typedef struct {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [7:0] rem;
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    logic clk;
    logic rst;
    pulse_train_if bus_if();

    pulse_train_gen #(.PULSE_W(PW), .GAP_W(GW), .REFRESH(RF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb_q[$];

    logic [7:0] codes [10];
    initial begin
        codes[0] = 8'b11000000; codes[1] = 8'b11111001; codes[2] = 8'b10100100;
        codes[3] = 8'b10110000; codes[4] = 8'b10011001; codes[5] = 8'b10010010;
        codes[6] = 8'b10000010; codes[7] = 8'b11111000; codes[8] = 8'b10000000;
        codes[9] = 8'b10010000;
    end

    // Reference model state
    logic       m_prev_start = 1'b0;
    logic       m_active     = 1'b0;
    int         m_t          = 0;
    int         m_n          = 0;
    int         m_cnt        = 0;
    logic [7:0] m_rem        = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step(output exp_t e);
        logic det;
        int   dsel;
        int   done_pulses;
        if (!rst) begin
            m_prev_start = 1'b0;
            m_active     = 1'b0;
            m_t          = 0;
            m_cnt        = 0;
            m_rem        = 8'd0;
            e.pulse = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.rem = 8'd0;
            e.an = 8'b11111110; e.seg = 8'b11000000;
        end else begin
            det          = bus_if.start && !m_prev_start;
            m_prev_start = bus_if.start;
            dsel         = (m_cnt / RF) % 2;
            m_cnt++;
            if (dsel == 0) begin
                e.an  = 8'b11111110;
                e.seg = codes[int'(m_rem) % 10];
            end else begin
                e.an  = 8'b11111101;
                e.seg = codes[int'(m_rem) / 10];
            end
            e.done = 1'b0; e.pulse = 1'b1; e.busy = 1'b0; e.rem = 8'd0;
            if (m_active) begin
                if (bus_if.abort) begin
                    m_active = 1'b0;
                end else begin
                    m_t++;
                    if (m_t == m_n * PER) begin
                        m_active = 1'b0;
                        e.done   = 1'b1;
                    end else begin
                        done_pulses = (m_t >= PW) ? ((m_t - PW) / PER + 1) : 0;
                        e.pulse = ((m_t % PER) < PW) ? 1'b0 : 1'b1;
                        e.busy  = 1'b1;
                        e.rem   = 8'(m_n - done_pulses);
                    end
                end
            end else if (det && !bus_if.abort) begin
                if (bus_if.n_pulses == 8'd0) begin
                    e.done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_t      = 0;
                    m_n      = (bus_if.n_pulses > 8'd99) ? 99 : int'(bus_if.n_pulses);
                    e.pulse  = 1'b0;
                    e.busy   = 1'b1;
                    e.rem    = 8'(m_n);
                end
            end
            m_rem = e.rem;
        end
    endtask

    // One clock: push the prediction, let the edge happen, pop and compare.
    task automatic tick();
        exp_t e;
        exp_t g;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("pulse_out", 32'(bus_if.pulse_out), 32'(g.pulse));
        chk("busy",      32'(bus_if.busy),      32'(g.busy));
        chk("done",      32'(bus_if.done),      32'(g.done));
        chk("remaining", 32'(bus_if.remaining), 32'(g.rem));
        chk("an",        32'(bus_if.an),        32'(g.an));
        chk("seg",       32'(bus_if.seg),       32'(g.seg));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst             = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.abort    = 1'b0;
        bus_if.n_pulses = 8'd0;

        // Reset, then idle with the display alternating digits
        ticks(2);
        rst = 1'b1;
        ticks(20);

        // Three-pulse train with start held high (no retrigger)
        bus_if.n_pulses = 8'd3;
        bus_if.start    = 1'b1;
        ticks(32);
        bus_if.start    = 1'b0;
        ticks(3);

        // Zero-length request: done strobe only
        bus_if.n_pulses = 8'd0;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        ticks(4);

        // Abort together with a start edge in IDLE: start ignored
        bus_if.n_pulses = 8'd2;
        bus_if.start    = 1'b1;
        bus_if.abort    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        bus_if.abort    = 1'b0;
        ticks(3);

        // Saturating request of 150 runs as 99 pulses
        bus_if.n_pulses = 8'd150;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        ticks(99 * PER + 4);

        // Five-pulse train aborted in its second LOW phase
        bus_if.n_pulses = 8'd5;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        ticks(PER);
        bus_if.abort    = 1'b1;
        tick();
        bus_if.abort    = 1'b0;
        ticks(10);

        // Fresh five-pulse train; n_pulses change after latching is ignored
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        bus_if.n_pulses = 8'd7;
        ticks(5 * PER + 4);

        // Reset in the middle of a HIGH phase while start edges
        bus_if.n_pulses = 8'd2;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        ticks(PW + 1);
        rst             = 1'b0;
        bus_if.start    = 1'b1;
        tick();
        rst             = 1'b1;
        bus_if.start    = 1'b0;
        ticks(12);
        bus_if.start    = 1'b1;
        tick();
        bus_if.start    = 1'b0;
        ticks(2 * PER + 3);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
